// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencer for a radix-2 single-delay-feedback FFT pipeline.
// Drives pipeline enable, per-stage butterfly bits and output qualifiers.
module fft_sdf_stage_ctrl #(
   parameter int LOG2N = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic             pipe_en,
   output logic [LOG2N-1:0] cnt,
   output logic [LOG2N-1:0] stage_bf,
   output logic             out_valid,
   output logic             out_first,
   output logic [LOG2N-1:0] out_idx,
   output logic             frame_err
);

   localparam int N = 1 << LOG2N;
   localparam logic [LOG2N-1:0] CNT_TOP   = LOG2N'(N - 1);
   localparam logic [LOG2N-1:0] FLUSH_END = LOG2N'(N - 2);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH
   } state_t;

   state_t           state;
   logic [LOG2N-1:0] fill;
   logic [LOG2N-1:0] flush_cnt;
   logic             accept;
   logic             last_ok;

   always_comb begin
      in_ready  = (state != FLUSH);
      accept    = in_valid & in_ready;
      pipe_en   = accept | (state == FLUSH);
      last_ok   = accept & in_last & (cnt == CNT_TOP);
      frame_err = accept & in_last & (cnt != CNT_TOP);
      // fill saturates once the delay lines hold a full frame of real data
      out_valid = (state == FLUSH) | (pipe_en & (fill == CNT_TOP));
      out_idx   = cnt + LOG2N'(1);
      out_first = out_valid & (out_idx == '0);
   end

   // stage s toggles with period N>>(s-1); offset aligns it to the frame start
   genvar s;
   for (s = 1; s <= LOG2N; s++) begin : g_bf
      logic [LOG2N-1:0] rot;
      assign rot = cnt + LOG2N'(N >> (s - 1));
      assign stage_bf[s-1] = rot[LOG2N-s];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         fill      <= '0;
         flush_cnt <= '0;
      end else begin
         if (pipe_en)
            cnt <= cnt + LOG2N'(1);
         if (accept && fill != CNT_TOP)
            fill <= fill + LOG2N'(1);
         unique case (state)
            IDLE: begin
               if (accept)
                  state <= RUN;
            end
            RUN: begin
               if (last_ok) begin
                  state     <= FLUSH;
                  flush_cnt <= '0;
               end
            end
            FLUSH: begin
               flush_cnt <= flush_cnt + LOG2N'(1);
               if (flush_cnt == FLUSH_END) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  fill      <= '0;
                  flush_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Scoreboard bench for fft_sdf_stage_ctrl (N=32).
// Output k of a stream carries bin index k mod 32; first when k mod 32 == 0.
module tb_fft_sdf_stage_ctrl;

   localparam int LOG2N = 5;
   localparam int N = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_last = 1'b0;
   logic             in_ready;
   logic             pipe_en;
   logic [LOG2N-1:0] cnt;
   logic [LOG2N-1:0] stage_bf;
   logic             out_valid;
   logic             out_first;
   logic [LOG2N-1:0] out_idx;
   logic             frame_err;

   typedef struct packed {
      logic             first;
      logic [LOG2N-1:0] idx;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   passed = 0;

   fft_sdf_stage_ctrl #(.LOG2N(LOG2N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .pipe_en   (pipe_en),
      .cnt       (cnt),
      .stage_bf  (stage_bf),
      .out_valid (out_valid),
      .out_first (out_first),
      .out_idx   (out_idx),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got === exp)
         passed++;
      else
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   task automatic push_out(input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.first = ((k % N) == 0);
         e.idx   = LOG2N'(k % N);
         q.push_back(e);
      end
   endtask

   task automatic cycle_r(input logic v, input logic l, input logic r);
      @(posedge clk);
      #1;
      in_valid = v;
      in_last  = l;
      rst      = r;
      @(negedge clk);
   endtask

   task automatic cycle(input logic v, input logic l);
      cycle_r(v, l, 1'b0);
   endtask

   task automatic flush_chk(input logic v);
      for (int f = 0; f < N - 1; f++) begin
         cycle(v, 1'b0);
         chk("flush_ready", in_ready, 0);
         chk("flush_en", pipe_en, 1);
         chk("flush_cnt", cnt, f);
      end
   endtask

   task automatic idle_chk();
      cycle(1'b0, 1'b0);
      chk("idle_ready", in_ready, 1);
      chk("idle_cnt", cnt, 0);
      chk("idle_en", pipe_en, 0);
      chk("idle_oval", out_valid, 0);
   endtask

   // monitor: every presented output must match the next queued expectation
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_out", out_idx, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("out_idx", out_idx, e.idx);
            chk("out_first", out_first, e.first);
         end
      end
   end

   initial begin
      // reset
      cycle_r(1'b0, 1'b0, 1'b1);
      cycle_r(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0);
      chk("rst_ready", in_ready, 1);
      chk("rst_en", pipe_en, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_bf", stage_bf, 0);
      chk("rst_oval", out_valid, 0);
      chk("rst_first", out_first, 0);
      chk("rst_idx", out_idx, 1);
      chk("rst_ferr", frame_err, 0);

      // in_last without in_valid is ignored
      cycle(1'b0, 1'b1);
      chk("lone_last_ferr", frame_err, 0);
      chk("lone_last_en", pipe_en, 0);

      // single frame
      push_out(N);
      for (int i = 0; i < N; i++) begin
         cycle(1'b1, i == N - 1);
         chk("f1_cnt", cnt, i);
         chk("f1_en", pipe_en, 1);
         chk("f1_oval", out_valid, i == N - 1);
      end
      flush_chk(1'b0);
      idle_chk();
      chk("f1_drained", q.size(), 0);

      // three back-to-back frames
      push_out(3 * N);
      for (int i = 0; i < 3 * N; i++) begin
         cycle(1'b1, i == 3 * N - 1);
         chk("f3_cnt", cnt, i % N);
         chk("f3_bf0", stage_bf[0], (i % N) >= 16);
         chk("f3_bf4", stage_bf[4], i % 2);
         chk("f3_ferr", frame_err, 0);
         chk("f3_oval", out_valid, i >= N - 1);
      end
      flush_chk(1'b0);
      idle_chk();
      chk("f3_drained", q.size(), 0);

      // early in_last, stall at cnt 10, flush with in_valid held high
      push_out(N);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, i == 7);
         chk("early_ferr", frame_err, i == 7);
         chk("early_ready", in_ready, 1);
         chk("early_cnt", cnt, i);
      end
      for (int j = 0; j < 5; j++) begin
         cycle(1'b0, 1'b0);
         chk("stall_en", pipe_en, 0);
         chk("stall_cnt", cnt, 10);
         chk("stall_oval", out_valid, 0);
      end
      for (int i = 10; i < N; i++) begin
         cycle(1'b1, i == N - 1);
         chk("resume_cnt", cnt, i);
      end
      flush_chk(1'b1);
      idle_chk();
      chk("f5_drained", q.size(), 0);

      // reset during FLUSH cycle 10
      push_out(11);
      for (int i = 0; i < N; i++)
         cycle(1'b1, i == N - 1);
      for (int f = 0; f < 10; f++) begin
         cycle(1'b0, 1'b0);
         chk("pre_rst_ready", in_ready, 0);
      end
      cycle_r(1'b0, 1'b0, 1'b1);
      idle_chk();
      chk("rst_drained", q.size(), 0);
      push_out(N);
      for (int i = 0; i < N; i++) begin
         cycle(1'b1, i == N - 1);
         chk("post_rst_oval", out_valid, i == N - 1);
      end
      flush_chk(1'b0);
      idle_chk();
      chk("final_drained", q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
